// File: rtl/gf180mcu_fd_sc_mcu9t5v0__deglitch_rx.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__deglitch_rx.sv - synchronising glitch-filter receiver with edge pulses and event register
module gf180mcu_fd_sc_mcu9t5v0__deglitch_rx #(
  parameter int       SYNC_STAGES = 2,
  parameter int       FILT_CYCLES = 4,
  parameter logic     RST_VAL     = 1'b0,
  parameter int       GCNT_W      = 8
) (
`ifdef USE_POWER_PINS
  inout  wire              VDD,
  inout  wire              VSS,
`endif
  input  logic              CLK,
  input  logic              RST,
  input  logic              I,
  output logic              Z,
  output logic              ZR,
  output logic              ZF,
  output logic              EVT_VLD,
  output logic              EVT_LVL,
  input  logic              EVT_ACK,
  output logic              OVF,
  output logic [GCNT_W-1:0] GCNT,
  input  logic              CLR
);

  localparam int CW = $clog2(FILT_CYCLES + 1);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   z_q, z_d;
  logic                   zr_q, zr_d;
  logic                   zf_q, zf_d;
  logic                   toggle;
  logic                   glitch;

  logic                   evt_vld_q, evt_vld_d;
  logic                   evt_lvl_q, evt_lvl_d;
  logic                   ovf_q, ovf_d;
  logic [GCNT_W-1:0]      gcnt_q, gcnt_d;
  logic                   evt_t;

  // Synchroniser: I enters at bit 0, S is the oldest sample.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], I};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      z_q     <= RST_VAL;
      zr_q    <= 1'b0;
      zf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      zr_q    <= zr_d;
      zf_q    <= zf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    toggle  = 1'b0;
    glitch  = 1'b0;
    unique case (state_q)
      ST_STABLE: begin
        if (s != z_q) begin
          if (FILT_CYCLES == 1) begin
            toggle = 1'b1;
          end else begin
            state_d = ST_PENDING;
            cnt_d   = CW'(1);
          end
        end
      end
      ST_PENDING: begin
        if (s == z_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
          glitch  = 1'b1;
        end else if (cnt_q == CW'(FILT_CYCLES - 1)) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
          toggle  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
    z_d  = z_q ^ toggle;
    zr_d = toggle & ~z_q;
    zf_d = toggle & z_q;
  end

  // An accepted toggle is the cycle in which ZR or ZF is high; Z already holds the new level.
  assign evt_t = zr_q | zf_q;

  always_comb begin
    evt_vld_d = evt_vld_q;
    evt_lvl_d = evt_lvl_q;
    ovf_d     = ovf_q;
    gcnt_d    = gcnt_q;
    if (evt_t) begin
      if (!evt_vld_q) begin
        evt_vld_d = 1'b1;
        evt_lvl_d = z_q;
      end else if (EVT_ACK) begin
        evt_lvl_d = z_q;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (evt_vld_q && EVT_ACK) begin
      evt_vld_d = 1'b0;
    end
    if (glitch && (gcnt_q != {GCNT_W{1'b1}})) begin
      gcnt_d = gcnt_q + GCNT_W'(1);
    end
    if (CLR) begin
      ovf_d  = 1'b0;
      gcnt_d = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      evt_vld_q <= 1'b0;
      evt_lvl_q <= 1'b0;
      ovf_q     <= 1'b0;
      gcnt_q    <= '0;
    end else begin
      evt_vld_q <= evt_vld_d;
      evt_lvl_q <= evt_lvl_d;
      ovf_q     <= ovf_d;
      gcnt_q    <= gcnt_d;
    end
  end

  assign Z       = z_q;
  assign ZR      = zr_q;
  assign ZF      = zf_q;
  assign EVT_VLD = evt_vld_q;
  assign EVT_LVL = evt_lvl_q;
  assign OVF     = ovf_q;
  assign GCNT    = gcnt_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__deglitch_rx.sv
// tb/tb_gf180mcu_fd_sc_mcu9t5v0__deglitch_rx.sv - directed bench for the deglitch receiver
module tb_gf180mcu_fd_sc_mcu9t5v0__deglitch_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       i0, ack0, clr0;
  logic       z0, zr0, zf0, vld0, lvl0, ovf0;
  logic [7:0] gcnt0;
  logic       i1, ack1, clr1;
  logic       z1, zr1, zf1, vld1, lvl1, ovf1;
  logic [7:0] gcnt1;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu9t5v0__deglitch_rx u_dut (
    .CLK(clk), .RST(rst), .I(i0), .Z(z0), .ZR(zr0), .ZF(zf0),
    .EVT_VLD(vld0), .EVT_LVL(lvl0), .EVT_ACK(ack0), .OVF(ovf0),
    .GCNT(gcnt0), .CLR(clr0)
  );

  gf180mcu_fd_sc_mcu9t5v0__deglitch_rx #(
    .SYNC_STAGES(3), .FILT_CYCLES(1), .RST_VAL(1'b1), .GCNT_W(8)
  ) u_dut1 (
    .CLK(clk), .RST(rst), .I(i1), .Z(z1), .ZR(zr1), .ZF(zf1),
    .EVT_VLD(vld1), .EVT_LVL(lvl1), .EVT_ACK(ack1), .OVF(ovf1),
    .GCNT(gcnt1), .CLR(clr1)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  logic seen;
  int   zr_at, zf_at;

  initial begin
    rst = 1'b1; i0 = 1'b0; ack0 = 1'b0; clr0 = 1'b0;
    i1 = 1'b1; ack1 = 1'b0; clr1 = 1'b0;
    ticks(2);
    rst = 1'b0;
    chk_eq("rst1_z1", z1, 1);

    // reset while the filter is pending
    i0 = 1'b1;
    ticks(4);
    rst = 1'b1;
    #1;
    chk_eq("rst_z", z0, 0);
    chk_eq("rst_flags", {zr0, zf0, vld0, lvl0, ovf0}, 0);
    chk_eq("rst_gcnt", gcnt0, 0);
    i0 = 1'b0; tick(); i0 = 1'b1; tick(); i0 = 1'b0;
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      seen |= zr0 | zf0 | vld0 | z0;
    end
    chk_eq("rst_quiet", seen, 0);
    chk_eq("rst_gcnt_after", gcnt0, 0);

    // latency: Z and ZR on edge 6 only
    i0 = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk_eq($sformatf("lat_z_e%0d", e), z0, (e >= 6) ? 1 : 0);
      chk_eq($sformatf("lat_zr_e%0d", e), zr0, (e == 6) ? 1 : 0);
      chk_eq($sformatf("lat_zf_e%0d", e), zf0, 0);
    end
    chk_eq("lat_vld", vld0, 1);
    chk_eq("lat_lvl", lvl0, 1);
    ack0 = 1'b1; tick(); ack0 = 1'b0;
    chk_eq("ack_vld", vld0, 0);
    i0 = 1'b0; ticks(10);
    ack0 = 1'b1; tick(); ack0 = 1'b0;
    chk_eq("back_low_z", z0, 0);
    chk_eq("back_low_vld", vld0, 0);

    // glitch: 3-clock high pulse is rejected
    i0 = 1'b1; ticks(3); i0 = 1'b0; ticks(5);
    chk_eq("gl_z", z0, 0);
    chk_eq("gl_gcnt", gcnt0, 1);
    chk_eq("gl_vld", vld0, 0);
    seen = 1'b0;
    for (int r = 1; r < 300; r++) begin
      i0 = 1'b1;
      for (int k = 0; k < 3; k++) begin tick(); seen |= zr0 | z0; end
      i0 = 1'b0;
      for (int k = 0; k < 5; k++) begin tick(); seen |= zr0 | z0; end
    end
    chk_eq("gl300_gcnt", gcnt0, 255);
    chk_eq("gl300_quiet", seen, 0);
    chk_eq("gl300_vld", vld0, 0);

    // overflow
    clr0 = 1'b1; tick(); clr0 = 1'b0;
    chk_eq("clr_gcnt", gcnt0, 0);
    i0 = 1'b1; ticks(10);
    i0 = 1'b0; ticks(10);
    chk_eq("ovf_vld", vld0, 1);
    chk_eq("ovf_lvl", lvl0, 1);
    chk_eq("ovf_set", ovf0, 1);
    clr0 = 1'b1; ack0 = 1'b1; tick(); clr0 = 1'b0; ack0 = 1'b0;
    chk_eq("ovf_clr", ovf0, 0);
    chk_eq("ovf_ack_vld", vld0, 0);

    // ack coincident with the second toggle
    i0 = 1'b1; ticks(10);
    chk_eq("sim_vld1", vld0, 1);
    i0 = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      tick();
      if (zf0) begin
        seen = 1'b1;
        ack0 = 1'b1; tick(); ack0 = 1'b0;
      end
    end
    chk_eq("sim_zf_seen", seen, 1);
    chk_eq("sim_vld", vld0, 1);
    chk_eq("sim_lvl", lvl0, 0);
    chk_eq("sim_ovf", ovf0, 0);

    // FILT_CYCLES=1, SYNC_STAGES=3: fall on edge 4
    i1 = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk_eq($sformatf("f1_z_e%0d", e), z1, (e < 4) ? 1 : 0);
      chk_eq($sformatf("f1_zf_e%0d", e), zf1, (e == 4) ? 1 : 0);
    end
    // one-clock pulse passes: rise on edge 4, fall on edge 5
    zr_at = 0; zf_at = 0;
    i1 = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 1) i1 = 1'b0;
      chk_eq($sformatf("f1_excl_e%0d", e), zr1 & zf1, 0);
      if (zr1) zr_at = e;
      if (zf1) zf_at = e;
    end
    chk_eq("f1_pulse_zr_at", zr_at, 4);
    chk_eq("f1_pulse_zf_at", zf_at, 5);
    chk_eq("f1_gcnt", gcnt1, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
